// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit seven-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the pattern for hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  blank;
    logic [7:0]  dp;
  } upd_t;

  localparam upd_t ACT_RST = '{
    value: 32'h0,
    blank: 8'hFF,
    dp:    8'h00
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-update handshake: one valid/ready
// transfer carries a full frame of digit data.
interface seg7_scan_ctrl_if;

  logic        valid;
  logic        ready;
  logic [31:0] value;
  logic [7:0]  blank;
  logic [7:0]  dp;

  modport master (
    output valid,
    output value,
    output blank,
    output dp,
    input  ready
  );

  modport slave (
    input  valid,
    input  value,
    input  blank,
    input  dp,
    output ready
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low
// seven-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner
// with a frame-aligned double-buffered update.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  seg7_scan_ctrl_if.slave  upd,
  output logic             frame_done,
  output logic [6:0]       SEG,
  output logic [7:0]       AN,
  output logic             DP
);

  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("seg7_scan_ctrl: CLK_HZ/DIGIT_HZ must be >= 2");
  end

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic             pend_vld;
  upd_t             pend;
  upd_t             act;
  logic             tick;
  logic             wrap;
  logic             accept;
  logic             commit;
  logic [3:0]       nib;
  logic [6:0]       seg_dec;

  assign upd.ready = ~pend_vld;
  assign accept    = upd.valid & ~pend_vld;
  assign tick      = enable & (presc == LAST);
  assign wrap      = tick & (idx == IDX_W'(NUM_DIGITS - 1));

  // Dark display has no frame to tear, so commit at once
  assign commit = pend_vld & (enable ? wrap : 1'b1);

  assign nib = act.value[{idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      if (!enable) begin
        presc <= '0;
        idx   <= '0;
      end else if (tick) begin
        presc <= '0;
        idx   <= idx + IDX_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      frame_done <= wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend     <= '0;
      act      <= ACT_RST;
    end else if (accept) begin
      pend_vld <= 1'b1;
      pend     <= '{
        value: upd.value,
        blank: upd.blank,
        dp:    upd.dp
      };
    end else if (commit) begin
      pend_vld <= 1'b0;
      act      <= pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SEG <= SEG_BLANK;
      AN  <= '1;
      DP  <= 1'b1;
    end else if (!enable || act.blank[idx]) begin
      SEG <= SEG_BLANK;
      AN  <= '1;
      DP  <= 1'b1;
    end else begin
      SEG <= seg_dec;
      AN  <= ~(8'b1 << idx);
      DP  <= ~act.dp[idx];
    end
  end

endmodule
